// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_pkg
// Purpose  : Shared types and constants for the PISO serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int c_DEFAULT_WIDTH = 4;
    localparam bit c_MSB_FIRST     = 1'b1;
    localparam bit c_LSB_FIRST     = 1'b0;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_shift_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_tx_if
// Purpose  : Producer-side load/ready handshake plus serial output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface piso_shift_tx_if #(
    parameter int WIDTH = piso_pkg::c_DEFAULT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] p_in;
    logic             ready;
    logic             q;
    logic             valid;
    logic             done;

    modport master (
        output load, p_in,
        input  ready, q, valid, done
    );

    modport slave (
        input  load, p_in,
        output ready, q, valid, done
    );
endinterface : piso_shift_tx_if
`default_nettype wire

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_tx
// Purpose  : Parallel-in serial-out transmitter with load/ready handshake,
//            valid qualifier and end-of-word pulse; streams words gap-free.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = c_MSB_FIRST
) (
    input  wire logic      clk,
    input  wire logic      reset,
    piso_shift_tx_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_adv;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_live;
    logic               w_last;
    logic               w_ready;
    logic               w_accept;
    logic               w_head;

    assign w_last   = (r_state == SHIFT) && (r_cnt == c_LAST);
    // r_live holds ready low until the first edge after reset release
    assign w_ready  = r_live && ((r_state == IDLE) || w_last);
    assign w_accept = bus.load && w_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head      = r_shift[WIDTH-1];
            assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head      = r_shift[0];
            assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)            w_state_nxt = SHIFT;
            SHIFT:   if (w_last && !w_accept) w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // Vacated bits fill with zero, so a finished word leaves no residue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= bus.p_in;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_shift <= w_shift_adv;
            r_cnt   <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    always_comb begin
        bus.ready = w_ready;
        bus.valid = (r_state == SHIFT);
        bus.q     = (r_state == SHIFT) && w_head;
        bus.done  = w_last;
    end

endmodule : piso_shift_tx
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_shift_tx
// Purpose  : Directed self-checking bench for MSB-first and LSB-first builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] r_rx;

    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(4)) if_m ();
    piso_shift_tx_if #(.WIDTH(4)) if_l ();

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    // 4-bit SIPO receiver: first bit received ends up in bit 3
    always @(posedge clk or posedge reset) begin
        if (reset)           r_rx <= 4'b0000;
        else if (if_m.valid) r_rx <= {r_rx[2:0], if_m.q};
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Packed as {ready, valid, done, q}
    function automatic logic [7:0] pk(input logic r, input logic v, input logic d, input logic s);
        return {4'b0000, r, v, d, s};
    endfunction

    function automatic logic [7:0] obs_m();
        return pk(if_m.ready, if_m.valid, if_m.done, if_m.q);
    endfunction

    function automatic logic [7:0] obs_l();
        return pk(if_l.ready, if_l.valid, if_l.done, if_l.q);
    endfunction

    task automatic drive(input logic ld, input logic [3:0] p);
        if_m.load = ld;
        if_m.p_in = p;
        if_l.load = ld;
        if_l.p_in = p;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m"}, obs_m(), pk(1'b1, 1'b0, 1'b0, 1'b0));
        check({tag, "_l"}, obs_l(), pk(1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    // Called at the negedge where bit 0 of w is visible; ld_mask[k]/p_mid
    // drive the inputs seen by the edge closing bit k.
    task automatic watch_word(input string tag, input logic [3:0] w,
                              input logic [3:0] ld_mask, input logic [3:0] p_mid);
        for (int k = 0; k < 4; k++) begin
            logic last;
            last = (k == 3);
            check($sformatf("%s_m_b%0d", tag, k), obs_m(), pk(last, 1'b1, last, w[3-k]));
            check($sformatf("%s_l_b%0d", tag, k), obs_l(), pk(last, 1'b1, last, w[k]));
            drive(ld_mask[k], p_mid);
            @(negedge clk);
        end
    endtask

    initial begin
        drive(1'b0, 4'b0000);
        repeat (5) @(negedge clk);
        check("rst_m", obs_m(), pk(1'b0, 1'b0, 1'b0, 1'b0));
        check("rst_l", obs_l(), pk(1'b0, 1'b0, 1'b0, 1'b0));
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // Single word, p_in wiggled after acceptance
        drive(1'b1, 4'b1011);
        @(negedge clk);
        watch_word("w1011", 4'b1011, 4'b0000, 4'b1111);
        check_idle("w1011_end");

        drive(1'b1, 4'b0001);
        @(negedge clk);
        watch_word("w0001", 4'b0001, 4'b0000, 4'b0000);
        check_idle("w0001_end");

        // Back-to-back: second word accepted in the done cycle
        drive(1'b1, 4'b1111);
        @(negedge clk);
        watch_word("b2b_a", 4'b1111, 4'b1111, 4'b0000);
        watch_word("b2b_b", 4'b0000, 4'b0000, 4'b0000);
        check_idle("b2b_end");

        // Mid-word load ignored and dropped before the closing edge
        drive(1'b1, 4'b1100);
        @(negedge clk);
        watch_word("ign", 4'b1100, 4'b0110, 4'b0110);
        check_idle("ign_end");
        @(negedge clk);
        check_idle("ign_after");

        // Asynchronous reset after the 2nd bit of 1010
        drive(1'b1, 4'b1010);
        @(negedge clk);
        drive(1'b0, 4'b0000);
        check("ar_m_b0", obs_m(), pk(1'b0, 1'b1, 1'b0, 1'b1));
        check("ar_l_b0", obs_l(), pk(1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("ar_m_b1", obs_m(), pk(1'b0, 1'b1, 1'b0, 1'b0));
        check("ar_l_b1", obs_l(), pk(1'b0, 1'b1, 1'b0, 1'b1));
        #2 reset = 1'b1;
        #1;
        check("ar_now_m", obs_m(), pk(1'b0, 1'b0, 1'b0, 1'b0));
        check("ar_now_l", obs_l(), pk(1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        check("ar_hold_m", obs_m(), pk(1'b0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        @(negedge clk);
        check_idle("ar_rel");
        @(negedge clk);
        check_idle("ar_rel2");
        @(negedge clk);
        check_idle("ar_rel3");

        // Loopback into the SIPO receiver
        drive(1'b1, 4'b1001);
        @(negedge clk);
        watch_word("loop", 4'b1001, 4'b0000, 4'b0000);
        check("loop_rx", {4'b0000, r_rx}, 8'b0000_1001);
        check_idle("loop_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_piso_shift_tx
`default_nettype wire

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out transmitter. It is the sending end for the team's 4-bit serial-in shift register: a parallel word is loaded, then driven out one bit per clock on a single serial line. It adds a load/ready handshake, a bit counter, a valid qualifier and an end-of-word pulse, so words can be streamed back-to-back without gaps. It sits between a parallel producer and the serial D input of the receiving shift register.

Parameters:
WIDTH, 4, word length in bits; legal range ≥2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  asynchronous, active-high reset.
load  input  1  producer request; a word transfers when load=1 and ready=1 at a rising edge.
p_in  input  WIDTH  parallel word; sampled only on an accepted load.
ready  output  1  block can accept a word this cycle.
q  output  1  serial data out; drives the receiver's D.
valid  output  1  q holds a real data bit this cycle.
done  output  1  one-cycle pulse marking the last bit of a word.

Behaviour:
- Reset is asynchronous and active-high. While reset=1: state=IDLE, shift register=0, counter=0, q=0, valid=0, done=0, ready=0. ready rises in the first cycle after reset deasserts.
- States:
  - IDLE: ready=1, valid=0, q=0, done=0.
  - SHIFT: valid=1; q = current head bit of the shift register.
- Accept: load&ready at edge T0 captures p_in and sets counter=0. The first bit appears on q after T0, during cycle T0..T1.
- Latency: 1 clock from the accepting edge to the first bit. A word occupies exactly WIDTH consecutive SHIFT cycles.
- Each SHIFT-cycle edge advances the head by one bit and increments the counter:
  - MSB_FIRST=1: shift left.
  - MSB_FIRST=0: shift right.
  - The vacated bit fills with 0.
- Last bit (counter==WIDTH-1):
  - done=1 and ready=1 in that same cycle.
  - If load=1 at the closing edge, the new word is captured and SHIFT continues with counter=0. There is no idle bubble, and valid stays 1 across the boundary.
  - If load=0, the next state is IDLE.
- load while ready=0 (mid-word): ignored. p_in is not sampled and the word in flight is unaffected. The producer holds load until it sees ready.
- p_in changes after acceptance have no effect.
- Reset mid-word: the word is aborted immediately and not resumed. After release the block is IDLE with no residual bits.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1; it wraps to 0 on the last bit.
- All outputs are registered or decoded from registered state only. There is no combinational path from load or p_in to any output, except ready feeding back into the producer's accept decision.

Decomposition:
- Shared package piso_pkg: state enum (IDLE, SHIFT), default WIDTH constant, MSB_FIRST encoding constants.
- No sub-module; counter, shift register and 2-state FSM stay flat in one module.
- Optional reuse: a generic mod-N counter, mod_counter, if the team already owns one.

Test Plan:
- Reset then single word: reset=1 for 100 ns, release; load=1 with p_in=4'b1011 for one cycle (MSB_FIRST=1) -> q=1,0,1,1 on 4 consecutive cycles, valid=1 on exactly those 4, done=1 only on the 4th, ready=0 on bits 1–3, then ready=1 and valid=0.
- LSB-first: MSB_FIRST=0, p_in=4'b0001 -> q=1,0,0,0; done on the 4th bit.
- Back-to-back: load held at 1, p_in=4'b1111 then 4'b0000 accepted in the done cycle -> 8 contiguous valid cycles with q=1,1,1,1,0,0,0,0; done pulses on cycles 4 and 8; valid never drops.
- Ignored load: mid-word, assert load with p_in=4'b0110 -> output of the current word unchanged; 0110 is not sent unless load is still high at the done-cycle edge.
- Reset mid-operation: assert reset after the 2nd bit of 4'b1010 -> q=0, valid=0, done=0, ready=0 immediately (asynchronous, before the next edge); after release, IDLE with ready=1 and no further bits.
- Loopback: connect q to the 4-bit SIPO receiver's D, send 4'b1001 -> after 4 valid clocks the receiver's parallel outputs equal 1001 in the receiver's bit order.
